// File: rtl/reg_bus_arb_pkg.sv
// reg_bus_arb_pkg: shared encodings for the two-port register-bus arbiter.
//   state_e : arbiter FSM states
//   op_e    : latched request kind
//   port_e  : requester identity, also used as the round-robin pointer
package reg_bus_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Wide enough for the largest read latency (15).
    localparam int CNT_W = 4;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction
endpackage

// File: rtl/reg_bus_arbiter_req_latch.sv
// reg_req_latch: holds one requester's single outstanding request.
//   clk, rst          : clock, synchronous active-high reset
//   rd, wr            : single-cycle request pulses (wr wins when both are high)
//   addr, writedata   : request payload, captured when a request is accepted
//   clr               : the arbiter has finished this port's request
//   pend              : a request is held
//   lat_addr/lat_data : latched payload
//   op                : latched request kind
//   ovf               : sticky, a pulse arrived while a request was held
module reg_req_latch
    import reg_bus_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] writedata,
    input  logic          clr,
    output logic          pend,
    output logic [AW-1:0] lat_addr,
    output logic [DW-1:0] lat_data,
    output op_e           op,
    output logic          ovf
);
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    op_e           op_q, op_d;
    logic          req, accept;

    // A pulse in the same cycle the held request completes is taken, not dropped.
    always_comb begin
        req    = rd | wr;
        accept = req && (!pend_q || clr);
        pend_d = accept || (pend_q && !clr);
        ovf_d  = ovf_q || (req && pend_q && !clr);
        addr_d = accept ? addr : addr_q;
        data_d = accept ? writedata : data_q;
        op_d   = accept ? (wr ? OP_WR : OP_RD) : op_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            op_q   <= OP_RD;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            addr_q <= addr_d;
            data_q <= data_d;
            op_q   <= op_d;
        end
    end

    assign pend     = pend_q;
    assign ovf      = ovf_q;
    assign lat_addr = addr_q;
    assign lat_data = data_q;
    assign op       = op_q;
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of one register-bank port between two requesters.
//   clk, rst                  : clock, synchronous active-high reset
//   a_* / b_* inputs          : addr, writedata, rd/wr single-cycle request pulses
//   a_* / b_* outputs         : wack and rvalid pulses, rdata (held), busy, sticky ovf
//   bus_addr, bus_writedata   : shared bank address/data, zero outside ISSUE
//   bus_rd, bus_wr            : shared bank strobes, one cycle per request
//   bus_readdata              : bank read data, valid RD_LAT cycles after bus_rd
module reg_bus_arbiter
    import reg_bus_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_writedata,
    input  logic          a_rd,
    input  logic          a_wr,
    output logic          a_wack,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          a_busy,
    output logic          a_ovf,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_writedata,
    input  logic          b_rd,
    input  logic          b_wr,
    output logic          b_wack,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          b_busy,
    output logic          b_ovf,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_writedata,
    output logic          bus_rd,
    output logic          bus_wr,
    input  logic [DW-1:0] bus_readdata
);
    logic             a_pend, b_pend, a_clr, b_clr;
    logic [AW-1:0]    a_laddr, b_laddr;
    logic [DW-1:0]    a_ldata, b_ldata;
    op_e              a_op, b_op;
    state_e           state_q, state_d;
    port_e            grant_q, grant_d, last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic             g_a, capture, done, issue;
    logic [AW-1:0]    g_addr;
    logic [DW-1:0]    g_data;
    op_e              g_op;

    reg_req_latch #(.AW(AW), .DW(DW)) u_a (
        .clk(clk), .rst(rst), .rd(a_rd), .wr(a_wr), .addr(a_addr), .writedata(a_writedata),
        .clr(a_clr), .pend(a_pend), .lat_addr(a_laddr), .lat_data(a_ldata), .op(a_op), .ovf(a_ovf)
    );

    reg_req_latch #(.AW(AW), .DW(DW)) u_b (
        .clk(clk), .rst(rst), .rd(b_rd), .wr(b_wr), .addr(b_addr), .writedata(b_writedata),
        .clr(b_clr), .pend(b_pend), .lat_addr(b_laddr), .lat_data(b_ldata), .op(b_op), .ovf(b_ovf)
    );

    // Granted-port view and transfer completion.
    always_comb begin
        g_a       = grant_q == PORT_A;
        g_addr    = g_a ? a_laddr : b_laddr;
        g_data    = g_a ? a_ldata : b_ldata;
        g_op      = g_a ? a_op : b_op;
        issue     = state_q == ISSUE;
        capture   = state_q == WAIT && cnt_q == CNT_W'(1);
        done      = (issue && g_op == OP_WR) || state_q == RESP;
        a_clr     = done && g_a;
        b_clr     = done && !g_a;
        a_rdata_d = (capture && g_a) ? bus_readdata : a_rdata_q;
        b_rdata_d = (capture && !g_a) ? bus_readdata : b_rdata_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (a_pend || b_pend) begin
                    // On a tie the port served least recently wins.
                    grant_d = (a_pend && b_pend) ? other_port(last_q) : (a_pend ? PORT_A : PORT_B);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (g_op == OP_WR) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = capture ? RESP : WAIT;
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= PORT_A;
            last_q    <= PORT_B;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Responses are suppressed while reset is sampled so an aborted transfer never acknowledges.
    always_comb begin
        bus_rd        = issue && g_op == OP_RD;
        bus_wr        = issue && g_op == OP_WR;
        bus_addr      = issue ? g_addr : '0;
        bus_writedata = issue ? g_data : '0;
        a_wack        = !rst && issue && g_op == OP_WR && g_a;
        b_wack        = !rst && issue && g_op == OP_WR && !g_a;
        a_rvalid      = !rst && state_q == RESP && g_a;
        b_rvalid      = !rst && state_q == RESP && !g_a;
    end

    assign a_busy  = a_pend;
    assign b_busy  = b_pend;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed checks of two arbiter builds (RD_LAT 1 and 3) against a transaction model.
module tb_reg_bus_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_writedata = '0, b_writedata = '0;
    logic [1:0] a_wack, a_rvalid, a_busy, a_ovf, b_wack, b_rvalid, b_busy, b_ovf, bus_rd, bus_wr;
    logic [DW-1:0] a_rdata[2], b_rdata[2], bus_writedata[2], bus_readdata[2];
    logic [AW-1:0] bus_addr[2];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reg_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst),
            .a_addr(a_addr), .a_writedata(a_writedata), .a_rd(a_rd), .a_wr(a_wr),
            .a_wack(a_wack[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]), .a_busy(a_busy[g]), .a_ovf(a_ovf[g]),
            .b_addr(b_addr), .b_writedata(b_writedata), .b_rd(b_rd), .b_wr(b_wr),
            .b_wack(b_wack[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]), .b_busy(b_busy[g]), .b_ovf(b_ovf[g]),
            .bus_addr(bus_addr[g]), .bus_writedata(bus_writedata[g]), .bus_rd(bus_rd[g]), .bus_wr(bus_wr[g]),
            .bus_readdata(bus_readdata[g])
        );
    end

    function automatic int lat_of(input int i);
        return i == 0 ? 1 : 3;
    endfunction

    function automatic logic [31:0] bank(input logic [7:0] a);
        return a == 8'h04 ? 32'h12345678 : {4{a}} ^ 32'hA5A5A5A5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Transaction model: each granted request is a numbered sequence of cycles.
    // Cycle 1 is the bus strobe; a write ends there, a read captures at LAT+1 and responds at LAT+2.
    bit mp[2][2], mw[2][2], mo[2][2], mact[2];
    logic [AW-1:0] ma[2][2];
    logic [DW-1:0] md[2][2], mr[2][2];
    int mlast[2], mwho[2], mk[2];
    bit minit = 1'b0;

    task automatic model_step(input int i);
        logic r[2], w[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] dt[2];
        bit clr[2];
        bit done;
        int p, lat;
        lat = lat_of(i);
        r = '{a_rd, b_rd};
        w = '{a_wr, b_wr};
        ad = '{a_addr, b_addr};
        dt = '{a_writedata, b_writedata};
        if (rst) begin
            for (int q = 0; q < 2; q++) begin
                mp[i][q] = 1'b0;
                mo[i][q] = 1'b0;
                mr[i][q] = '0;
            end
            mlast[i] = 1;
            mact[i] = 1'b0;
            return;
        end
        p = mwho[i];
        done = mact[i] && (mw[i][p] ? mk[i] == 1 : mk[i] == lat + 2);
        if (mact[i] && !mw[i][p] && mk[i] == lat + 1) mr[i][p] = bus_readdata[i];
        clr[0] = done && p == 0;
        clr[1] = done && p == 1;
        if (!mact[i]) begin
            if (mp[i][0] || mp[i][1]) begin
                mwho[i] = (mp[i][0] && mp[i][1]) ? 1 - mlast[i] : (mp[i][0] ? 0 : 1);
                mact[i] = 1'b1;
                mk[i] = 1;
            end
        end else if (done) begin
            mact[i] = 1'b0;
            mlast[i] = p;
        end else begin
            mk[i]++;
        end
        for (int q = 0; q < 2; q++) begin
            if (r[q] || w[q]) begin
                if (!mp[i][q] || clr[q]) begin
                    mp[i][q] = 1'b1;
                    ma[i][q] = ad[q];
                    md[i][q] = dt[q];
                    mw[i][q] = w[q];
                end else begin
                    mo[i][q] = 1'b1;
                end
            end else if (clr[q]) begin
                mp[i][q] = 1'b0;
            end
        end
    endtask

    task automatic model_cmp(input int i);
        bit iss;
        int w, lat;
        logic [63:0] got, exp;
        lat = lat_of(i);
        w = mwho[i];
        iss = mact[i] && mk[i] == 1;
        chk($sformatf("model_bus%0d", i), {bus_rd[i], bus_wr[i], bus_addr[i], bus_writedata[i]},
            iss ? {!mw[i][w], mw[i][w], ma[i][w], md[i][w]} : 42'd0);
        for (int p = 0; p < 2; p++) begin
            exp = {!rst && iss && w == p && mw[i][p],
                   !rst && mact[i] && w == p && !mw[i][p] && mk[i] == lat + 2,
                   mp[i][p], mo[i][p], mr[i][p]};
            got = p == 0 ? {a_wack[i], a_rvalid[i], a_busy[i], a_ovf[i], a_rdata[i]}
                         : {b_wack[i], b_rvalid[i], b_busy[i], b_ovf[i], b_rdata[i]};
            chk($sformatf("model_port%s_%0d", p == 0 ? "A" : "B", i), got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
        if (rst) minit = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (minit) for (int i = 0; i < 2; i++) model_cmp(i);
    end

    // Bank: data is valid only in the cycle RD_LAT after bus_rd; junk otherwise.
    int due[2];
    logic [DW-1:0] val[2];
    initial begin
        due = '{-1, -1};
        bus_readdata[0] = '0;
        bus_readdata[1] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bus_readdata[i] = (cyc == due[i]) ? val[i] : (32'hBAD00000 | 32'(cyc));
                if (bus_rd[i]) begin
                    due[i] = cyc + lat_of(i);
                    val[i] = bank(bus_addr[i]);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step();
        chk("rst_outputs", {a_wack, a_rvalid, a_busy, a_ovf, b_wack, b_rvalid, b_busy, b_ovf, bus_rd, bus_wr}, 0);
        chk("rst_data", {a_rdata[0], bus_addr[0], bus_writedata[0]}, 0);

        // A write
        a_wr = 1; a_addr = 8'h10; a_writedata = 32'hDEADBEEF;
        step(); a_wr = 0;
        chk("t1_busy_c1", a_busy[0], 1);
        step();
        chk("t1_bus_c2", {bus_wr[0], bus_rd[0], bus_addr[0], bus_writedata[0]}, {2'b10, 8'h10, 32'hDEADBEEF});
        chk("t1_wack_c2", {a_wack[0], b_wack[0], a_wack[1]}, 3'b101);
        step();
        chk("t1_idle_c3", {a_busy[0], bus_wr[0], a_wack[0]}, 0);
        step(2);

        // B read on both latencies
        b_rd = 1; b_addr = 8'h04;
        step(); b_rd = 0;
        step();
        chk("t2_busrd_c2", {bus_rd[0], bus_rd[1], bus_addr[0], bus_addr[1]}, {2'b11, 8'h04, 8'h04});
        step();
        chk("t2_rv_c3", b_rvalid[0], 0);
        step();
        chk("t2_rv_c4", {b_rvalid[0], b_rdata[0]}, {1'b1, 32'h12345678});
        chk("t2_ardata_kept", a_rdata[0], 0);
        step();
        chk("t2_lat3_rv_c5", b_rvalid[1], 0);
        step();
        chk("t2_lat3_rv_c6", {b_rvalid[1], b_rdata[1]}, {1'b1, 32'h12345678});
        step(2);

        // Tie, then fairness on a repeated tie
        for (int r = 0; r < 2; r++) begin
            a_wr = 1; a_addr = 8'h01; a_writedata = 32'h11;
            b_wr = 1; b_addr = 8'h02; b_writedata = 32'h22;
            step(); a_wr = 0; b_wr = 0;
            step();
            chk($sformatf("t3_first_%0d", r), {bus_wr[0], bus_addr[0], bus_writedata[0], a_wack[0], b_wack[0], bus_addr[1]},
                {1'b1, 8'h01, 32'h11, 2'b10, 8'h01});
            step(2);
            chk($sformatf("t3_second_%0d", r), {bus_wr[0], bus_addr[0], bus_writedata[0], a_wack[0], b_wack[0]},
                {1'b1, 8'h02, 32'h22, 2'b01});
            step(6);
        end

        // Overflow, then acceptance in the rvalid cycle
        a_rd = 1; a_addr = 8'h20;
        step(); a_rd = 0;
        step();
        chk("t4_busrd_c2", {bus_rd[0], bus_addr[0]}, {1'b1, 8'h20});
        a_rd = 1; a_addr = 8'h30;
        step(); a_rd = 0;
        chk("t4_ovf_c3", {a_ovf[0], bus_rd[0]}, 2'b10);
        step();
        chk("t4_rv_c4", {a_rvalid[0], a_rdata[0], a_ovf[0]}, {1'b1, 32'h85858585, 1'b1});
        a_rd = 1; a_addr = 8'h30;
        step(); a_rd = 0;
        chk("t4_accept_c5", {a_busy[0], a_ovf[0]}, 2'b11);
        step();
        chk("t4_busrd_c6", {bus_rd[0], bus_addr[0]}, {1'b1, 8'h30});
        step(2);
        chk("t4_rv_c8", {a_rvalid[0], a_rdata[0]}, {1'b1, 32'h95959595});
        step(3);

        // Reset during the second WAIT cycle of the RD_LAT=3 build
        a_rd = 1; a_addr = 8'h40;
        step(); a_rd = 0;
        step(3);
        rst = 1;
        step(); rst = 0;
        chk("t5_after_rst", {a_busy[1], a_ovf[1], a_ovf[0], bus_rd[1], bus_wr[1], a_busy[0], a_rdata[1]}, 0);
        for (int k = 0; k < 5; k++) begin
            chk("t5_no_rvalid", {a_rvalid[1], a_rvalid[0]}, 0);
            step();
        end
        a_wr = 1; a_addr = 8'h41; a_writedata = 32'h5;
        step(); a_wr = 0;
        step();
        chk("t5_fresh_wr", {bus_wr[1], a_wack[1], bus_addr[1], bus_writedata[1]}, {2'b11, 8'h41, 32'h5});
        step(2);

        // Simultaneous rd and wr: write wins, no overflow
        a_wr = 1; a_rd = 1; a_addr = 8'h50; a_writedata = 32'h77;
        step(); a_wr = 0; a_rd = 0;
        step();
        chk("t6_wr_wins", {bus_wr[0], bus_rd[0], a_wack[0], bus_addr[0]}, {3'b101, 8'h50});
        step();
        chk("t6_no_ovf", {a_ovf[0], a_busy[0]}, 0);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
